// File: rtl/fifo_wr_burst_arb_pkg.sv
// fifo_wr_arb_pkg: state encoding and sizing helpers for the FIFO write-port burst arbiter
package fifo_wr_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction
endpackage

// File: rtl/fifo_wr_burst_arb_if.sv
// fifo_wr_burst_arb_if: producer handshakes, FIFO write port and status around the burst arbiter
interface fifo_wr_burst_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int WR_DEPTH_WIDTH = 11
);
  logic req0_req, req0_valid, req0_gnt, req0_ready;
  logic [DATA_WIDTH-1:0] req0_data;
  logic req1_req, req1_valid, req1_gnt, req1_ready;
  logic [DATA_WIDTH-1:0] req1_data;
  logic fifo_wr_en, fifo_wr_full;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic [WR_DEPTH_WIDTH:0] fifo_wr_water_level;
  logic burst_done, overflow_err;
  modport slave (
    input  req0_req, req0_valid, req0_data, req1_req, req1_valid, req1_data,
           fifo_wr_full, fifo_wr_water_level,
    output req0_gnt, req0_ready, req1_gnt, req1_ready, fifo_wr_en, fifo_wr_data,
           burst_done, overflow_err
  );
  modport master (
    output req0_req, req0_valid, req0_data, req1_req, req1_valid, req1_data,
           fifo_wr_full, fifo_wr_water_level,
    input  req0_gnt, req0_ready, req1_gnt, req1_ready, fifo_wr_en, fifo_wr_data,
           burst_done, overflow_err
  );
endinterface

// File: rtl/fifo_wr_burst_arb.sv
// fifo_wr_burst_arb: round-robin, burst-granular arbiter between two producers and one FIFO write port
module fifo_wr_burst_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WR_DEPTH_WIDTH = 11,
  parameter int BURST_LEN = 16,
  parameter int ADMIT_MARGIN = 2
) (
  input logic clk,
  input logic rst,
  fifo_wr_burst_arb_if.slave bus
);
  localparam int CW = beat_cnt_w(BURST_LEN);
  localparam int LW = WR_DEPTH_WIDTH + 2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [LW-1:0] NEED = LW'(BURST_LEN + ADMIT_MARGIN);
  localparam logic [LW-1:0] CAP = LW'(1) << WR_DEPTH_WIDTH;
  state_t r_state;
  logic r_rr_ptr, r_gnt0, r_gnt1, r_overflow;
  logic [CW-1:0] r_beat_cnt;
  logic w_space_ok, w_pick1, w_valid, w_accept, w_last;
  logic [DATA_WIDTH-1:0] w_data;
  // admission needs room for the whole burst plus slack for the lagging water level
  assign w_space_ok = ({1'b0, bus.fifo_wr_water_level} + NEED) <= CAP;
  assign w_pick1 = bus.req1_req & (~bus.req0_req | r_rr_ptr);
  assign w_valid = (r_gnt0 & bus.req0_valid) | (r_gnt1 & bus.req1_valid);
  assign w_accept = w_valid & ~bus.fifo_wr_full;
  assign w_last = w_accept & (r_beat_cnt == LAST_BEAT);
  assign w_data = r_gnt0 ? bus.req0_data : r_gnt1 ? bus.req1_data : '0;
  assign bus.req0_gnt = r_gnt0;
  assign bus.req1_gnt = r_gnt1;
  assign bus.req0_ready = r_gnt0 & ~bus.fifo_wr_full;
  assign bus.req1_ready = r_gnt1 & ~bus.fifo_wr_full;
  assign bus.fifo_wr_en = w_accept;
  assign bus.fifo_wr_data = w_data;
  assign bus.burst_done = w_last;
  assign bus.overflow_err = r_overflow;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr_ptr <= 1'b0;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_overflow <= 1'b0;
      r_beat_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_space_ok && (bus.req0_req || bus.req1_req)) begin
        r_state <= BURST;
        r_gnt0 <= ~w_pick1;
        r_gnt1 <= w_pick1;
        r_beat_cnt <= '0;
      end
    end else begin
      r_overflow <= r_overflow | bus.fifo_wr_full;
      if (w_accept) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (w_last) begin
        r_state <= IDLE;
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
        r_rr_ptr <= r_gnt0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_burst_arb.sv
// tb_fifo_wr_burst_arb: scoreboard bench; expected write stream built from burst order and round-robin rules
module tb_fifo_wr_burst_arb;
  localparam int DW = 32, AW = 11, BL = 16, MARGIN = 2;
  localparam int CAPW = 1 << AW;
  typedef struct { logic [DW-1:0] data; bit last; } beat_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_burst_arb_if #(.DATA_WIDTH(DW), .WR_DEPTH_WIDTH(AW)) bus();
  fifo_wr_burst_arb #(.DATA_WIDTH(DW), .WR_DEPTH_WIDTH(AW), .BURST_LEN(BL), .ADMIT_MARGIN(MARGIN))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0;
  beat_t exp_q[$];
  int plan_q[$];
  logic [DW-1:0] src0[$], src1[$];
  int model_ptr = 0;
  int vmode = 0, fmode = 0, lmode = 0, lvl = 0, bc = -1;
  int n_wr = 0, n_done = 0, n_gcyc = 0, n_rise = 0, max_gap = 0, idle_run = 0;
  bit prev_g = 1'b0, ovf_exp = 1'b0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic reset_stats();
    n_wr = 0; n_done = 0; n_gcyc = 0; n_rise = 0; max_gap = 0;
  endtask
  // one burst for requester r: its words go to the producer and, in grant order, to the scoreboard
  task automatic plan_burst(input int r);
    logic [DW-1:0] w;
    for (int i = 0; i < BL; i++) begin
      w = $urandom;
      if (r == 0) src0.push_back(w); else src1.push_back(w);
      exp_q.push_back('{data: w, last: (i == BL - 1)});
    end
    plan_q.push_back(r);
    model_ptr = 1 - r;
  endtask
  task automatic drive();
    bit g, v;
    g = bus.req0_gnt | bus.req1_gnt;
    bc = g ? bc + 1 : -1;
    v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (bc % 2 == 0) : ($urandom_range(0, 99) < 70);
    bus.req0_req = src0.size() >= BL;
    bus.req1_req = src1.size() >= BL;
    bus.req0_valid = v && src0.size() > 0;
    bus.req1_valid = v && src1.size() > 0;
    bus.req0_data = src0.size() > 0 ? src0[0] : '0;
    bus.req1_data = src1.size() > 0 ? src1[0] : '0;
    bus.fifo_wr_full = (fmode == 1) ? (bc >= 5 && bc <= 7) : (fmode == 2) ? ($urandom_range(0, 99) < 10) : 1'b0;
    bus.fifo_wr_water_level = (AW+1)'((lmode != 0) ? $urandom_range(0, CAPW - 8) : lvl);
  endtask
  task automatic step();
    bit a0, a1;
    @(negedge clk);
    a0 = bus.req0_valid & bus.req0_ready;
    a1 = bus.req1_valid & bus.req1_ready;
    @(posedge clk);
    #1;
    if (a0 && src0.size() > 0) src0.delete(0);
    if (a1 && src1.size() > 0) src1.delete(0);
    drive();
  endtask
  task automatic drain(input int maxc);
    int c;
    c = 0;
    step();
    while ((exp_q.size() > 0 || bus.req0_gnt || bus.req1_gnt) && c < maxc) begin
      step();
      c++;
    end
    step();
    chk("drain_left", exp_q.size(), 0);
    chk("plan_left", plan_q.size(), 0);
  endtask
  always @(negedge clk) begin : mon
    beat_t e;
    bit g0, g1;
    int p;
    if (rst) begin
      prev_g = 1'b0;
      ovf_exp = 1'b0;
      idle_run = 0;
    end else begin
      g0 = bus.req0_gnt;
      g1 = bus.req1_gnt;
      chk("gnt_exclusive", g0 & g1, 0);
      chk("ready0", bus.req0_ready, g0 & ~bus.fifo_wr_full);
      chk("ready1", bus.req1_ready, g1 & ~bus.fifo_wr_full);
      chk("wr_en", bus.fifo_wr_en, ((g0 & bus.req0_valid) | (g1 & bus.req1_valid)) & ~bus.fifo_wr_full);
      chk("overflow_err", bus.overflow_err, ovf_exp);
      ovf_exp = ovf_exp | ((g0 | g1) & bus.fifo_wr_full);
      if (!(g0 | g1)) chk("idle_data", bus.fifo_wr_data, 0);
      if ((g0 | g1) && !prev_g) begin
        if (n_rise > 0 && idle_run > max_gap) max_gap = idle_run;
        n_rise++;
        chk("grant_planned", plan_q.size() > 0, 1);
        if (plan_q.size() > 0) begin
          p = plan_q.pop_front();
          chk("grant_id", g1, p);
        end
      end
      if (g0 | g1) begin
        n_gcyc++;
        idle_run = 0;
      end else idle_run++;
      if (bus.fifo_wr_en) begin
        n_wr++;
        chk("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wr_data", bus.fifo_wr_data, e.data);
          chk("burst_done", bus.burst_done, e.last);
        end
      end else chk("burst_done_idle", bus.burst_done, 0);
      if (bus.burst_done) n_done++;
      prev_g = g0 | g1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
  initial begin
    drive();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
    chk("rst_gnt0", bus.req0_gnt, 0);
    chk("rst_gnt1", bus.req1_gnt, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_wr_en", bus.fifo_wr_en, 0);
    chk("rst_wr_data", bus.fifo_wr_data, 0);
    chk("rst_done", bus.burst_done, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    reset_stats();
    plan_burst(0);
    drain(100);
    chk("single_writes", n_wr, 16);
    chk("single_gnt_cycles", n_gcyc, 16);
    chk("single_done", n_done, 1);
    reset_stats();
    for (int k = 0; k < 8; k++) plan_burst(model_ptr);
    drain(400);
    chk("alt_writes", n_wr, 128);
    chk("alt_rises", n_rise, 8);
    chk("alt_max_gap", max_gap, 1);
    reset_stats();
    lvl = CAPW - BL - MARGIN;
    plan_burst(0);
    step();
    step();
    chk("level_2030_admit", bus.req0_gnt, 1);
    drain(100);
    reset_stats();
    lvl = CAPW - BL - MARGIN + 1;
    plan_burst(1);
    repeat (20) step();
    chk("level_2031_block", n_rise, 0);
    lvl = CAPW - BL - MARGIN;
    drain(100);
    chk("level_drop_grant", n_rise, 1);
    lvl = 0;
    reset_stats();
    vmode = 1;
    plan_burst(0);
    drain(100);
    chk("gap_writes", n_wr, 16);
    chk("gap_gnt_cycles", n_gcyc, 31);
    vmode = 0;
    reset_stats();
    fmode = 1;
    plan_burst(0);
    drain(100);
    fmode = 0;
    chk("full_writes", n_wr, 16);
    chk("full_gnt_cycles", n_gcyc, 19);
    repeat (3) step();
    chk("full_ovf_sticky", bus.overflow_err, 1);
    reset_stats();
    vmode = 2; fmode = 2; lmode = 1;
    for (int k = 0; k < 12; k++) plan_burst(model_ptr);
    drain(3000);
    chk("rand_writes", n_wr, 192);
    chk("rand_rises", n_rise, 12);
    vmode = 0; fmode = 0; lmode = 0;
    if (model_ptr == 0) begin
      plan_burst(0);
      drain(100);
    end
    reset_stats();
    plan_burst(0);
    for (int c = 0; c < 100 && n_wr < 5; c++) step();
    chk("rst_mid_beats", n_wr, 5);
    chk("rst_mid_ovf_before", bus.overflow_err, 1);
    rst = 1'b1;
    step();
    src0.delete();
    src1.delete();
    exp_q.delete();
    plan_q.delete();
    model_ptr = 0;
    rst = 1'b0;
    drive();
    chk("rst_mid_gnt0", bus.req0_gnt, 0);
    chk("rst_mid_wr_en", bus.fifo_wr_en, 0);
    chk("rst_mid_ovf", bus.overflow_err, 0);
    reset_stats();
    plan_burst(0);
    plan_burst(1);
    drain(200);
    chk("post_rst_pair_writes", n_wr, 32);
    reset_stats();
    plan_burst(1);
    drain(100);
    chk("post_rst_req1_writes", n_wr, 16);
    chk("post_rst_req1_done", n_done, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
